// File: rtl/fifo_control.sv
// FIFO pointer/occupancy controller: drives memory strobes and addresses, tracks
// occupancy and status flags, and latches overflow/underflow until init or reset.
module fifo_control #(
   parameter int address_width = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     init,
   input  logic [address_width:0]   umbral_alto,
   input  logic [address_width:0]   umbral_bajo,
   input  logic                     push,
   input  logic                     pop,
   output logic                     wr_enable,
   output logic                     rd_enable,
   output logic [address_width-1:0] wr_ptr,
   output logic [address_width-1:0] rd_ptr,
   output logic [address_width:0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic                     error,
   output logic [2:0]               state
);

   localparam int D = 1 << address_width;
   localparam logic [address_width:0]   DEPTH   = (address_width+1)'(D);
   localparam logic [address_width:0]   CNT_ONE = (address_width+1)'(1);
   localparam logic [address_width-1:0] PTR_ONE = address_width'(1);

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

   state_t                   state_q, state_d;
   logic [address_width-1:0] wr_ptr_q, wr_ptr_d;
   logic [address_width-1:0] rd_ptr_q, rd_ptr_d;
   logic [address_width:0]   count_q, count_d;
   logic [address_width:0]   alto_q, alto_d;
   logic [address_width:0]   bajo_q, bajo_d;
   logic                     error_q, error_d;

   logic xfer_en;
   logic pop_ok;
   logic push_ok;
   logic overflow;
   logic underflow;

   // Flags decode straight from the registered occupancy.
   assign full         = (count_q == DEPTH);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= alto_q);
   assign almost_empty = (count_q <= bajo_q);

   // Transfers only in IDLE/ACTIVE; an init request suppresses them so INIT is entered cleanly.
   assign xfer_en   = ((state_q == ST_IDLE) || (state_q == ST_ACTIVE)) && !init;
   assign pop_ok    = xfer_en & pop & ~empty;
   assign push_ok   = xfer_en & push & (~full | pop_ok);
   assign overflow  = xfer_en & push & full & ~pop_ok;
   assign underflow = xfer_en & pop & empty;

   assign wr_enable = push_ok;
   assign rd_enable = pop_ok;
   assign wr_ptr    = wr_ptr_q;
   assign rd_ptr    = rd_ptr_q;
   assign count     = count_q;
   assign error     = error_q;
   assign state     = state_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      alto_d   = alto_q;
      bajo_d   = bajo_q;
      error_d  = error_q;

      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;

      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      if ((state_q == ST_INIT) || init) begin
         alto_d = umbral_alto;
         bajo_d = umbral_bajo;
      end

      if (init)                       error_d = 1'b0;
      else if (overflow || underflow) error_d = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      if (init) begin
         state_d = ST_INIT;
      end else begin
         case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   state_d = ST_IDLE;
            ST_IDLE: begin
               if (overflow || underflow) state_d = ST_ERROR;
               else if (count_d != '0)    state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
               if (overflow || underflow) state_d = ST_ERROR;
               else if (count_d == '0)    state_d = ST_IDLE;
            end
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_RESET;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_RESET;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         alto_q   <= '0;
         bajo_q   <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         alto_q   <= alto_d;
         bajo_q   <= bajo_d;
         error_q  <= error_d;
      end
   end

endmodule

// File: tb/tb_fifo_control.sv
// Directed bench for fifo_control (D=4): init, fill/wrap, full push+pop,
// overflow, underflow, error clearing and asynchronous reset mid-burst.
module tb_fifo_control;

   logic       clk;
   logic       reset;
   logic       init;
   logic [2:0] umbral_alto;
   logic [2:0] umbral_bajo;
   logic       push;
   logic       pop;
   logic       wr_enable;
   logic       rd_enable;
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [2:0] count;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic       error;
   logic [2:0] state;

   int n_checks = 0;
   int n_fail   = 0;

   fifo_control #(.address_width(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .init         (init),
      .umbral_alto  (umbral_alto),
      .umbral_bajo  (umbral_bajo),
      .push         (push),
      .pop          (pop),
      .wr_enable    (wr_enable),
      .rd_enable    (rd_enable),
      .wr_ptr       (wr_ptr),
      .rd_ptr       (rd_ptr),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .error        (error),
      .state        (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; init = 1'b0; push = 1'b1; pop = 1'b1;
      umbral_alto = 3'd3; umbral_bajo = 3'd1;
      #2;
      check("rst_state", state, 0);
      check("rst_count", count, 0);
      check("rst_wr_ptr", wr_ptr, 0);
      check("rst_rd_ptr", rd_ptr, 0);
      check("rst_error", error, 0);
      check("rst_wr_en", wr_enable, 0);
      check("rst_rd_en", rd_enable, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_aempty", almost_empty, 1);

      push = 1'b0; pop = 1'b0; init = 1'b1; reset = 1'b1;
      tick();
      check("init_state", state, 1);
      init = 1'b0; push = 1'b1;
      #1;
      check("init_wr_en", wr_enable, 0);
      tick();
      check("idle_state", state, 2);
      check("idle_count", count, 0);
      check("idle_empty", empty, 1);
      check("idle_aempty", almost_empty, 1);

      for (int i = 1; i <= 4; i++) begin
         #1;
         check("fill_wr_en", wr_enable, 1);
         tick();
         check("fill_count", count, i);
         check("fill_state", state, 3);
         check("fill_wr_ptr", wr_ptr, i % 4);
         check("fill_afull", almost_full, (i >= 3) ? 1 : 0);
         check("fill_full", full, (i == 4) ? 1 : 0);
         check("fill_aempty", almost_empty, (i <= 1) ? 1 : 0);
      end

      pop = 1'b1;
      #1;
      check("both_full_wr_en", wr_enable, 1);
      check("both_full_rd_en", rd_enable, 1);
      tick();
      check("both_full_count", count, 4);
      check("both_full_error", error, 0);
      check("both_full_wr_ptr", wr_ptr, 1);
      check("both_full_rd_ptr", rd_ptr, 1);

      pop = 1'b0;
      #1;
      check("ovf_wr_en", wr_enable, 0);
      tick();
      check("ovf_error", error, 1);
      check("ovf_state", state, 4);
      check("ovf_wr_ptr", wr_ptr, 1);
      check("ovf_count", count, 4);

      push = 1'b0; pop = 1'b1;
      #1;
      check("err_rd_en", rd_enable, 0);
      tick();
      check("err_rd_ptr", rd_ptr, 1);
      check("err_count", count, 4);
      check("err_sticky", error, 1);

      pop = 1'b0; init = 1'b1;
      tick();
      check("clr1_error", error, 0);
      check("clr1_state", state, 1);
      check("clr1_count", count, 4);
      check("clr1_wr_ptr", wr_ptr, 1);
      init = 1'b0;
      tick();
      check("clr1_idle", state, 2);
      tick();
      check("clr1_active", state, 3);

      pop = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("drain_count", count, 4 - i);
         check("drain_rd_ptr", rd_ptr, (1 + i) % 4);
      end
      check("drain_state", state, 2);
      check("drain_empty", empty, 1);

      #1;
      check("udf_rd_en", rd_enable, 0);
      tick();
      check("udf_error", error, 1);
      check("udf_state", state, 4);
      check("udf_count", count, 0);

      pop = 1'b0; init = 1'b1;
      tick();
      check("clr2_error", error, 0);
      check("clr2_state", state, 1);
      init = 1'b0;
      tick();
      check("clr2_idle", state, 2);

      push = 1'b1; pop = 1'b1;
      #1;
      check("both_empty_wr_en", wr_enable, 1);
      check("both_empty_rd_en", rd_enable, 0);
      tick();
      check("both_empty_count", count, 1);
      check("both_empty_error", error, 1);
      check("both_empty_state", state, 4);
      check("both_empty_wr_ptr", wr_ptr, 2);

      push = 1'b0; pop = 1'b0; init = 1'b1;
      tick();
      init = 1'b0;
      tick();
      check("clr3_idle", state, 2);
      tick();
      check("clr3_active", state, 3);

      push = 1'b1;
      tick();
      check("burst_count", count, 2);
      check("burst_wr_ptr", wr_ptr, 3);
      #2;
      reset = 1'b0;
      #1;
      check("async_state", state, 0);
      check("async_count", count, 0);
      check("async_wr_ptr", wr_ptr, 0);
      check("async_rd_ptr", rd_ptr, 0);
      check("async_error", error, 0);
      check("async_wr_en", wr_enable, 0);
      check("async_rd_en", rd_enable, 0);
      check("async_empty", empty, 1);
      check("async_full", full, 0);
      check("async_aempty", almost_empty, 1);

      push = 1'b0;
      reset = 1'b1;
      tick();
      check("rerun_init", state, 1);
      check("rerun_count", count, 0);
      tick();
      check("rerun_idle", state, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
